// File: rtl/secuenciador_contador_if.sv
// Control/status bundle between the board controls and the run controller.
// There is no valid/ready pairing here: start/load are commands sampled only in IDLE,
// stop/pause are sampled every cycle in RUN/PAUSE, and tick/done are single-cycle strobes.
interface secuenciador_contador_if;
  logic       start;
  logic       stop;
  logic       pause;
  logic       dir;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] limit;
  logic [3:0] count;
  logic       tick;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  modport master (
    output start, stop, pause, dir, load, load_val, limit,
    input  count, tick, busy, done, state_dbg
  );

  modport slave (
    input  start, stop, pause, dir, load, load_val, limit,
    output count, tick, busy, done, state_dbg
  );
endinterface

// File: rtl/secuenciador_contador.sv
// Run controller: prescales clk into count-enable ticks and sequences a 4-bit
// count through load/start/pause/stop and a one-cycle terminal DONE state.
module secuenciador_contador #(
  parameter int DIV   = 50_000_000,
  parameter int DIV_W = 26
) (
  input logic                    clk,
  input logic                    rst,
  secuenciador_contador_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(DIV - 1);

  state_t           state;
  logic [DIV_W-1:0] pre;
  logic [3:0]       count;
  logic             at_last;
  logic [3:0]       next_count;

  assign at_last    = (pre == PRE_LAST);
  assign next_count = bus.dir ? (count + 4'd1) : (count - 4'd1);

  assign bus.tick      = (state == RUN) & at_last & ~bus.stop & ~bus.pause;
  assign bus.count     = count;
  assign bus.busy      = (state == RUN) | (state == PAUSE);
  assign bus.done      = (state == DONE);
  assign bus.state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pre   <= '0;
      count <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.load) count <= bus.load_val;
          if (bus.start) begin
            state <= RUN;
            pre   <= '0;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state <= IDLE;
            pre   <= '0;
          end else if (bus.pause) begin
            state <= PAUSE;
          end else if (at_last) begin
            pre   <= '0;
            count <= next_count;
            if (next_count == bus.limit) state <= DONE;
          end else begin
            pre <= pre + DIV_W'(1);
          end
        end
        PAUSE: begin
          if (bus.stop) begin
            state <= IDLE;
            pre   <= '0;
          end else if (!bus.pause) begin
            state <= RUN;
            // The release cycle counts as run time, except when the tick is
            // already due: holding pre lets that tick fire in the next cycle.
            if (!at_last) pre <= pre + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_contador.sv
// Bench for secuenciador_contador with DIV=4: vector table, hand-written corner
// sequences and randomized traffic against a cycle-countdown reference model.
module tb_secuenciador_contador;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  secuenciador_contador_if bus ();

  secuenciador_contador #(.DIV(DIV), .DIV_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       start, stop, pause, dir, load;
    logic [3:0] load_val, limit;
    logic [3:0] exp_count;
    logic       exp_tick, exp_busy, exp_done;
  } vec_t;

  vec_t vecs[17];
  logic [3:0] exp_q[$];

  // Reference model: mode, count and cycles left until the next tick.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_mode, m_count, m_left;
  bit model_on = 1'b0;

  function automatic vec_t mk(logic st, sp, pa, d, ld, logic [3:0] lv, lim,
                              logic [3:0] c, logic t, b, dn);
    vec_t v;
    v.start = st; v.stop = sp; v.pause = pa; v.dir = d; v.load = ld;
    v.load_val = lv; v.limit = lim;
    v.exp_count = c; v.exp_tick = t; v.exp_busy = b; v.exp_done = dn;
    return v;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dut_out();
    return {1'b0, bus.count, bus.tick, bus.busy, bus.done};
  endfunction

  function automatic logic [7:0] model_out();
    logic t;
    t = (m_mode == M_RUN) && (m_left == 1) && !bus.stop && !bus.pause;
    return {1'b0, 4'(m_count), t, (m_mode == M_RUN) || (m_mode == M_PAUSE),
            (m_mode == M_DONE)};
  endfunction

  task automatic model_update();
    if (rst) begin
      m_mode = M_IDLE; m_count = 0; m_left = DIV;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (bus.load) m_count = int'(bus.load_val);
          if (bus.start) begin m_mode = M_RUN; m_left = DIV; end
        end
        M_RUN: begin
          if (bus.stop) begin m_mode = M_IDLE; m_left = DIV; end
          else if (bus.pause) m_mode = M_PAUSE;
          else if (m_left == 1) begin
            m_count = (m_count + (bus.dir ? 1 : 15)) % 16;
            m_left  = DIV;
            if (m_count == int'(bus.limit)) m_mode = M_DONE;
          end else m_left--;
        end
        M_PAUSE: begin
          if (bus.stop) begin m_mode = M_IDLE; m_left = DIV; end
          else if (!bus.pause) begin
            m_mode = M_RUN;
            if (m_left > 1) m_left--;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic set_in(logic st, sp, pa, d, ld, logic [3:0] lv, lim);
    bus.start = st; bus.stop = sp; bus.pause = pa; bus.dir = d; bus.load = ld;
    bus.load_val = lv; bus.limit = lim;
  endtask

  // Called mid-cycle with inputs applied; returns at the next falling edge.
  task automatic step();
    #1;
    if (model_on) chk("model", dut_out(), model_out());
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 0, 1, 1, 4'd3, 4'd6, 4'd0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 1, 0, 4'd3, 4'd6, 4'd3, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 1, 0, 4'd3, 4'd6, 4'd3, 0, 1, 0);
    vecs[3]  = mk(0, 0, 0, 1, 0, 4'd3, 4'd6, 4'd3, 0, 1, 0);
    vecs[4]  = mk(0, 0, 0, 1, 0, 4'd3, 4'd6, 4'd3, 0, 1, 0);
    vecs[5]  = mk(0, 0, 0, 1, 0, 4'd3, 4'd6, 4'd3, 1, 1, 0);
    vecs[6]  = mk(0, 0, 0, 1, 0, 4'd3, 4'd6, 4'd4, 0, 1, 0);
    vecs[7]  = mk(0, 0, 0, 1, 0, 4'd3, 4'd6, 4'd4, 0, 1, 0);
    vecs[8]  = mk(0, 0, 0, 1, 0, 4'd3, 4'd6, 4'd4, 0, 1, 0);
    vecs[9]  = mk(0, 0, 0, 1, 0, 4'd3, 4'd6, 4'd4, 1, 1, 0);
    vecs[10] = mk(0, 0, 0, 1, 0, 4'd3, 4'd6, 4'd5, 0, 1, 0);
    vecs[11] = mk(0, 0, 0, 1, 0, 4'd3, 4'd6, 4'd5, 0, 1, 0);
    vecs[12] = mk(0, 0, 0, 1, 0, 4'd3, 4'd6, 4'd5, 0, 1, 0);
    vecs[13] = mk(0, 0, 0, 1, 0, 4'd3, 4'd6, 4'd5, 1, 1, 0);
    vecs[14] = mk(1, 1, 0, 1, 1, 4'd9, 4'd6, 4'd6, 0, 0, 1);
    vecs[15] = mk(0, 1, 1, 1, 0, 4'd9, 4'd6, 4'd6, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 1, 0, 4'd9, 4'd6, 4'd6, 0, 0, 0);

    // Clock/reset: three reset cycles with random inputs.
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 4'd0, 4'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             4'($urandom), 4'($urandom));
      step();
      model_on = 1'b1;
    end
    rst = 1'b0;
    set_in(0, 0, 0, 1, 0, 4'd0, 4'd0);
    #1 chk("reset_values", dut_out(), 8'h00);

    // Up-count to limit, plus DONE/IDLE ignoring start, load, stop and pause.
    for (int i = 0; i < 17; i++) begin
      set_in(vecs[i].start, vecs[i].stop, vecs[i].pause, vecs[i].dir, vecs[i].load,
             vecs[i].load_val, vecs[i].limit);
      #1 chk($sformatf("vec%0d", i), dut_out(),
             {1'b0, vecs[i].exp_count, vecs[i].exp_tick, vecs[i].exp_busy, vecs[i].exp_done});
      step();
    end

    // Down wrap 1 -> 0 -> 15 -> 14, then a single done pulse.
    set_in(0, 0, 0, 0, 1, 4'd1, 4'd14); step();
    set_in(1, 0, 0, 0, 0, 4'd1, 4'd14); step();
    set_in(0, 0, 0, 0, 0, 4'd1, 4'd14);
    repeat (4) step();
    #1 chk("down_0", 8'(bus.count), 8'd0);
    repeat (4) step();
    #1 chk("down_15", 8'(bus.count), 8'd15);
    repeat (4) step();
    #1 chk("down_14_done", dut_out(), {1'b0, 4'd14, 1'b0, 1'b0, 1'b1});
    step();
    #1 chk("down_done_once", 8'(bus.done), 8'd0);

    // Pause at pre==2 for 10 cycles; load and start together begin from 0.
    set_in(1, 0, 0, 1, 1, 4'd0, 4'd9); step();
    set_in(0, 0, 0, 1, 0, 4'd0, 4'd9);
    repeat (2) step();
    bus.pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 chk($sformatf("pause_hold%0d", i), {bus.count, bus.tick}, {4'd0, 1'b0});
      step();
    end
    bus.pause = 1'b0;
    #1 chk("pause_release", 8'(bus.tick), 8'd0);
    step();
    #1 chk("pause_tick", 8'(bus.tick), 8'd1);
    step();
    #1 chk("pause_count", 8'(bus.count), 8'd1);
    bus.stop = 1'b1; step(); bus.stop = 1'b0;

    // Stop in the tick cycle at count 2, then restart.
    set_in(1, 0, 0, 1, 1, 4'd1, 4'd9); step();
    set_in(0, 0, 0, 1, 0, 4'd1, 4'd9);
    repeat (4) step();
    repeat (3) step();
    bus.stop = 1'b1;
    #1 chk("stop_tick_cycle", dut_out(), {1'b0, 4'd2, 1'b0, 1'b1, 1'b0});
    step();
    bus.stop = 1'b0;
    #1 chk("stop_after", dut_out(), {1'b0, 4'd2, 1'b0, 1'b0, 1'b0});
    bus.start = 1'b1; step(); bus.start = 1'b0;
    repeat (4) step();
    #1 chk("stop_restart", dut_out(), {1'b0, 4'd3, 1'b0, 1'b1, 1'b0});
    bus.stop = 1'b1; step(); bus.stop = 1'b0;

    // Reset raised between edges changes nothing until the edge.
    set_in(1, 0, 0, 1, 1, 4'd7, 4'd2); step();
    set_in(0, 0, 0, 1, 0, 4'd7, 4'd2);
    repeat (4) step();
    rst = 1'b1;
    #1 chk("rst_mid_cycle", dut_out(), {1'b0, 4'd8, 1'b0, 1'b1, 1'b0});
    step();
    rst = 1'b0;
    #1 chk("rst_after_edge", dut_out(), 8'h00);

    // Start at limit: sixteen steps through the wrap before done.
    set_in(1, 0, 0, 1, 1, 4'd5, 4'd5); step();
    set_in(0, 0, 0, 1, 0, 4'd5, 4'd5);
    for (int v = 6; v < 22; v++) exp_q.push_back(4'(v % 16));
    begin
      int ticks = 0;
      bit seen_done = 1'b0;
      logic [3:0] last = 4'd5;
      for (int c = 0; c < 200 && !seen_done; c++) begin
        #1;
        if (bus.count !== last) begin
          if (exp_q.size() == 0) chk("limit_extra_step", 8'(bus.count), 8'hff);
          else chk("limit_seq", 8'(bus.count), 8'(exp_q.pop_front()));
          last = bus.count;
        end
        if (bus.done === 1'b1) seen_done = 1'b1;
        else begin
          if (bus.tick === 1'b1) ticks++;
          step();
        end
      end
      chk("limit_done_seen", 8'(seen_done), 8'd1);
      chk("limit_ticks", 8'(ticks), 8'd16);
      chk("limit_queue_empty", 8'(exp_q.size()), 8'd0);
      chk("limit_final", 8'(bus.count), 8'd5);
      step();
    end

    // Randomized traffic checked by the model inside step().
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
             $urandom_range(0, 7) == 0, 1'($urandom), $urandom_range(0, 7) == 0,
             4'($urandom), ($urandom_range(0, 31) == 0) ? 4'($urandom) : bus.limit);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/secuenciador_contador.md
# secuenciador_contador

Run controller for the 4-bit divided counter path. It owns the clock prescaler that turns the 50 MHz system clock into one-cycle count-enable ticks, and it sequences the 4-bit count through load, start, pause, stop and terminal-count states. It sits between the board controls (buttons/switches) and the count display logic, and it replaces free-running enable with a controlled run/stop sequence.

## Interface
Parameters:
- `DIV`, 50_000_000: clock cycles per count tick. Legal range is 2 to 2^DIV_W−1.
- `DIV_W`, 26: prescaler width in bits.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  begin run. Sampled only in IDLE.
- `stop`  in  1  abort run. Sampled in RUN and PAUSE.
- `pause`  in  1  level input. While high in RUN/PAUSE, the prescaler and count are frozen.
- `dir`  in  1  step direction: 1 = up, 0 = down. Sampled on each tick.
- `load`  in  1  load `load_val` into the count. Sampled only in IDLE.
- `load_val`  in  4  value to load.
- `limit`  in  4  terminal count value.
- `count`  out  4  current count (registered).
- `tick`  out  1  one-cycle count-enable strobe.
- `busy`  out  1  high in RUN or PAUSE.
- `done`  out  1  one-cycle pulse when the count reaches `limit`.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Internal prescaler `pre` is DIV_W bits wide.
- Reset (synchronous, checked at the clk edge): state=IDLE, pre=0, count=0, tick=0, busy=0, done=0. Reset overrides every other input.
- **IDLE:**
  - `load` → count=load_val.
  - `start` → RUN, pre=0.
  - If `load` and `start` are high together, both apply: the run begins from load_val.
  - `stop` and `pause` are ignored.
- **RUN:**
  - pre increments each cycle and wraps at DIV−1 to 0.
  - `tick` = (state==RUN) & (pre==DIV−1) & ~stop & ~pause. This is combinational from registered state and the inputs.
  - On a tick edge, count steps by ±1 per `dir`, with modulo-16 wrap: 15→0 going up, 0→15 going down.
  - If the post-step value equals `limit`, the next state is DONE.
- Priority within RUN/PAUSE: stop > pause > tick.
  - `stop` → IDLE, pre=0, count held, no done.
  - `pause` high in RUN → PAUSE; pre and count hold.
- **PAUSE:**
  - `pause` low → RUN, with pre resuming from its held value.
  - `stop` → IDLE.
- **DONE:** lasts exactly one cycle with done=1, then returns to IDLE. count holds at `limit`. start, load and stop are ignored during this cycle.
- Limit comparison happens only after a step. Starting with count==limit therefore runs a full 16 ticks before DONE.
- `limit` and `dir` may change mid-run. The new values are used at the next tick.
- busy = (state==RUN) | (state==PAUSE). done = (state==DONE). Both are decoded from the state register.

## Timing
- Define the start edge as edge 0. Then:
  - The first tick is high during the cycle before edge DIV.
  - count shows its new value after edge DIV.
  - Each subsequent step follows DIV cycles later.
- Terminal step at edge N: done is high in cycle N..N+1, and busy drops after edge N.
- Pause: each cycle `pause` is high adds exactly one cycle of delay to the pending tick. No tick is lost or duplicated.
- Stop or reset mid-run takes effect at the next edge. No tick is emitted in a cycle where `stop` is high.
- A tick coinciding with `stop` is suppressed: count does not step.

## Test plan
All scenarios use DIV=4.
- **Reset values:** Hold rst for 3 cycles with random inputs → count=0, tick=0, busy=0, done=0. Then raise rst between edges → no change until the next edge.
- **Up-count to limit:** load=1 with load_val=3, then start with dir=1, limit=6:
  - tick fires every 4 cycles;
  - count becomes 4, 5, 6 after edges 4, 8, 12;
  - done=1 for exactly one cycle after edge 12;
  - busy=0 after edge 12.
- **Down wrap:** load_val=1, dir=0, limit=14 → count goes 0, 15, 14, then one done pulse.
- **Pause:** Start from 0 with limit=9. Raise pause when pre==2 and hold it 10 cycles:
  - count and pre are frozen and tick=0 throughout;
  - the tick appears 1 cycle after pause falls;
  - count=1.
- **Stop mid-run:** Assert stop in the tick cycle at count=2 → count stays 2, no step, busy=0, done never asserted. A following start gives its first step 4 cycles later, to 3.
- **Start at limit:** load_val=5, limit=5, dir=1, start → exactly 16 ticks, the count passes 15→0, and done fires when the count returns to 5.
